dmem_lsu_ctrl: RTL and testbench
================================

// Module: dmem_lsu_ctrl
// PURPOSE
//  Load/store front-end that drives the byte-column data memory (word-addressed, 1-cycle read
//  latency, per-byte write enables). Accepts CPU byte-addressed ld/st requests.
//  Produces memory controls: word addr, byte we mask, lane-aligned din, spec_ld/valid_st.
//  Returns aligned, sign/zero-extended load data one cycle after the memory read.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width of the data memory (byte addr = ADDR_WIDTH+2 bits)
//  TAG_WIDTH   5   width of request tag echoed on the load response (e.g. dest reg)
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high reset
//  req_valid    in   1             request valid
//  req_ready    out  1             request accepted when req_valid && req_ready
//  req_st       in   1             1=store, 0=load
//  req_size     in   2             0=byte, 1=half, 2=word, 3=reserved (error)
//  req_signed   in   1             load: sign-extend (1) or zero-extend (0)
//  req_addr     in   ADDR_WIDTH+2  byte address
//  req_wdata    in   32            store data, right-justified
//  req_tag      in   TAG_WIDTH     echoed on rsp_tag
//  mem_addr     out  ADDR_WIDTH    word address to memory
//  mem_we       out  4             byte-lane write enables
//  mem_din      out  32            lane-aligned store data
//  mem_valid_st out  1             store strobe
//  mem_spec_ld  out  1             read strobe; mem_dout valid next cycle
//  mem_dout     in   32            memory read data (registered inside memory)
//  rsp_valid    out  1             load response / error pulse (no backpressure)
//  rsp_data     out  32            extended load data; 0 on error
//  rsp_tag      out  TAG_WIDTH     tag of responding request
//  rsp_err      out  1             misaligned or reserved-size request
// BEHAVIOUR
//  - Controls are combinational from the accepted request (cycle T); the load response is at T+1.
//  - req_ready = !reset && state==IDLE. With the macro off, the block is always IDLE: 1 req/cycle.
//  - Store: mem_valid_st=1, mem_addr=addr[ADDR_WIDTH+1:2], o=addr[1:0].
//    Byte: we=1<<o, wdata[7:0] replicated to all lanes.
//    Half: we=4'b0011<<o, wdata[15:0] replicated. Word: we=4'hF. No response for a store.
//  - Load: mem_spec_ld=1, mem_we=0. Tag/size/signed/offset registered.
//    At T+1: rsp_valid=1, rsp_data = selected lane(s) of mem_dout shifted to bit 0 and extended.
//  - Error: size==3, half with addr[0]=1, or word with addr[1:0]!=0 (macro off).
//    No mem strobes. rsp_valid=1, rsp_err=1, rsp_data=0, rsp_tag=req_tag at T+1.
//    A store error also gives a response.
//  - Back-to-back: a load at T and a store at T+1 to the same word are legal. The load returns
//    pre-store data (memory read-before-write ordering).
//  - Strobes are idle when no request is accepted: mem_we=0, mem_valid_st=0, mem_spec_ld=0.
//  - Reset (sync): state=IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tag=0.
//    All mem strobes are 0 while reset is high; an in-flight load/split is dropped silently.
// CONFIGURATION
//  DMEM_LSU_MISALIGN_EN defined: misaligned half/word requests are split into two accesses
//  (size==3 remains an error).
//    FSM IDLE->SPLIT on accepting a misaligned request; SPLIT->IDLE after one cycle;
//    req_ready=0 in SPLIT.
//    T:   word A, lanes o..3 (low bytes of datum).
//    T+1: word A+1 (mod 2^ADDR_WIDTH, wraps to 0), remaining lanes 0..(o+n-5), n=2|4 bytes.
//    Store: we/din for each part. Load: T+1 latches part-1 bytes; response at T+2 merges
//    part-1 bytes (low) with mem_dout lanes (high), then extends. rsp_err=0.
//  Not defined: the FSM is absent; misaligned requests take the error path above.
// TESTING
//  1. St word 0xDEADBEEF @0x010 (mem_we=F, mem_addr=4), then ld word signed @0x010
//     -> rsp_data=0xDEADBEEF one cycle after spec_ld, tag echoed.
//  2. St byte 0x80 @0x013 -> we=4'b1000, din=0x80808080.
//     Ld byte signed @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
//  3. Ld half @0x012 after test 1 -> unsigned 0x0000DEAD; ld half @0x011, macro off
//     -> rsp_err=1, rsp_data=0, no spec_ld.
//  4. Macro on: st word 0x11223344 @0x00E -> T: addr 3, we=1100; T+1: addr 4, we=0011;
//     req_ready=0 at T+1. Ld word @0x00E -> 0x11223344 at T+2.
//  5. Macro on: ld word @ byte addr 0xFFD (ADDR_WIDTH=10) -> second access mem_addr=0 (wrap).
//  6. Reset asserted in SPLIT cycle -> no response, strobes 0, req_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_ctrl
// Purpose  : Load/store front-end for a word-addressed, byte-column data
//            memory with 1-cycle read latency and per-byte write enables.
//            Converts byte-addressed CPU requests into memory strobes and
//            returns aligned, sign/zero-extended load data.
// Ports    : clk_i/reset_i        clock, synchronous active-high reset
//            req_*_i / req_ready_o CPU request (valid/ready handshake)
//            mem_*_o / mem_dout_i  memory controls and registered read data
//            rsp_*_o               load / error response (no backpressure)
// Config   : DMEM_LSU_MISALIGN_EN - when defined, word-crossing half/word
//            requests are split into two accesses; otherwise they error.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_st_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_signed_i,
   input  logic [ADDR_WIDTH+1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   input  logic [TAG_WIDTH-1:0]  req_tag_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_we_o,
   output logic [31:0]           mem_din_o,
   output logic                  mem_valid_st_o,
   output logic                  mem_spec_ld_o,
   input  logic [31:0]           mem_dout_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_data_o,
   output logic [TAG_WIDTH-1:0]  rsp_tag_o,
   output logic                  rsp_err_o
);

   // Byte rotations: left places datum byte 0 on lane 'n'; right brings lane 'n' to byte 0.
   function automatic logic [31:0] rol_bytes(input logic [31:0] d, input logic [1:0] n);
      case (n)
         2'd0:    rol_bytes = d;
         2'd1:    rol_bytes = {d[23:0], d[31:24]};
         2'd2:    rol_bytes = {d[15:0], d[31:16]};
         default: rol_bytes = {d[7:0],  d[31:8]};
      endcase
   endfunction

   function automatic logic [31:0] ror_bytes(input logic [31:0] d, input logic [1:0] n);
      case (n)
         2'd0:    ror_bytes = d;
         2'd1:    ror_bytes = {d[7:0],  d[31:8]};
         2'd2:    ror_bytes = {d[15:0], d[31:16]};
         default: ror_bytes = {d[23:0], d[31:24]};
      endcase
   endfunction

   logic [1:0]            off;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  accept;
   logic                  err;
   logic [3:0]            mask;
   logic [3:0]            we_lo;
   logic [31:0]           repl;
   logic [31:0]           din_rot;

   assign off     = req_addr_i[1:0];
   assign waddr   = req_addr_i[ADDR_WIDTH+1:2];
   assign accept  = req_valid_i && req_ready_o;

   always_comb begin
      mask = 4'b1111;
      repl = req_wdata_i;
      case (req_size_i)
         2'd0: begin
            mask = 4'b0001;
            repl = {4{req_wdata_i[7:0]}};
         end
         2'd1: begin
            mask = 4'b0011;
            repl = {2{req_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Rotating the datum by the offset puts the low bytes on lanes o..3 and the
   // remaining bytes on lanes 0.., so both halves of a split share one din.
   assign din_rot = rol_bytes(repl, off);

   logic                  pend_q;
   logic                  err_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [1:0]            size_q;
   logic                  sgn_q;
   logic [1:0]            off_q;
   logic [31:0]           rot;
   logic [31:0]           merged;
   logic [31:0]           ext;

   assign rot = ror_bytes(mem_dout_i, off_q);

`ifdef DMEM_LSU_MISALIGN_EN
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SPLIT = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [7:0]            we_wide;
   logic                  split;
   logic                  merge_q;
   logic                  st2_q;
   logic [31:0]           part1_q;
   logic [31:0]           din2_q;
   logic [3:0]            we2_q;
   logic [ADDR_WIDTH-1:0] addr2_q;

   assign we_wide     = {4'b0000, mask} << off;
   assign we_lo       = we_wide[3:0];
   assign err         = (req_size_i == 2'd3);
   assign split       = !err && (we_wide[7:4] != 4'b0000);
   assign req_ready_o = !reset_i && (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      if (state_q == S_SPLIT)
         state_d = S_IDLE;
      else if (accept && split)
         state_d = S_SPLIT;
   end

   // Part-1 bytes occupy the low (4-o) bytes of the datum; the rest come from word A+1.
   always_comb begin
      merged = rot;
      if (merge_q) begin
         for (int k = 0; k < 4; k++) begin
            if (k + int'(off_q) < 4)
               merged[8*k +: 8] = part1_q[8*k +: 8];
         end
      end
   end
`else
   assign we_lo       = mask << off;
   assign err         = (req_size_i == 2'd3) ||
                        ((req_size_i == 2'd1) && off[0]) ||
                        ((req_size_i == 2'd2) && (off != 2'd0));
   assign req_ready_o = !reset_i;
   assign merged      = rot;
`endif

   always_comb begin
      mem_addr_o     = waddr;
      mem_din_o      = din_rot;
      mem_we_o       = 4'b0000;
      mem_valid_st_o = 1'b0;
      mem_spec_ld_o  = 1'b0;
`ifdef DMEM_LSU_MISALIGN_EN
      if (state_q == S_SPLIT) begin
         mem_addr_o = addr2_q;
         mem_din_o  = din2_q;
         if (st2_q) begin
            mem_we_o       = we2_q;
            mem_valid_st_o = 1'b1;
         end else begin
            mem_spec_ld_o  = 1'b1;
         end
      end else
`endif
      if (accept && !err) begin
         if (req_st_i) begin
            mem_we_o       = we_lo;
            mem_valid_st_o = 1'b1;
         end else begin
            mem_spec_ld_o  = 1'b1;
         end
      end
      // Strobes must never reach memory while reset is high (covers the split cycle).
      if (reset_i) begin
         mem_we_o       = 4'b0000;
         mem_valid_st_o = 1'b0;
         mem_spec_ld_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         tag_q   <= '0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         off_q   <= 2'd0;
`ifdef DMEM_LSU_MISALIGN_EN
         state_q <= S_IDLE;
         merge_q <= 1'b0;
         st2_q   <= 1'b0;
         part1_q <= 32'd0;
         din2_q  <= 32'd0;
         we2_q   <= 4'b0000;
         addr2_q <= '0;
`endif
      end else begin
         pend_q <= 1'b0;
         err_q  <= 1'b0;
         if (accept) begin
            tag_q  <= req_tag_i;
            size_q <= req_size_i;
            sgn_q  <= req_signed_i;
            off_q  <= off;
            if (err) begin
               pend_q <= 1'b1;
               err_q  <= 1'b1;
            end else if (!req_st_i) begin
               pend_q <= 1'b1;
            end
         end
`ifdef DMEM_LSU_MISALIGN_EN
         state_q <= state_d;
         merge_q <= 1'b0;
         if (accept && split) begin
            // A split load responds only after its second access.
            pend_q  <= 1'b0;
            st2_q   <= req_st_i;
            din2_q  <= din_rot;
            we2_q   <= we_wide[7:4];
            addr2_q <= waddr + ADDR_WIDTH'(1);
         end
         if (state_q == S_SPLIT && !st2_q) begin
            pend_q  <= 1'b1;
            merge_q <= 1'b1;
            part1_q <= rot;
         end
`endif
      end
   end

   always_comb begin
      case (size_q)
         2'd0:    ext = {{24{sgn_q & merged[7]}},  merged[7:0]};
         2'd1:    ext = {{16{sgn_q & merged[15]}}, merged[15:0]};
         default: ext = merged;
      endcase
   end

   assign rsp_valid_o = pend_q && !reset_i;
   assign rsp_err_o   = err_q && rsp_valid_o;
   assign rsp_data_o  = (rsp_valid_o && !err_q) ? ext : 32'd0;
   assign rsp_tag_o   = rsp_valid_o ? tag_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu_ctrl
// Purpose  : Directed self-checking bench for dmem_lsu_ctrl with a simple
//            byte-column memory model (1-cycle read, read-before-write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;
   localparam int AW = 10;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_st = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_signed = 1'b0;
   logic [AW+1:0] req_addr = '0;
   logic [31:0]   req_wdata = 32'd0;
   logic [TW-1:0] req_tag = '0;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_we;
   logic [31:0]   mem_din;
   logic          mem_valid_st;
   logic          mem_spec_ld;
   logic [31:0]   mem_dout = 32'd0;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic [TW-1:0] rsp_tag;
   logic          rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:(1<<AW)-1];

   dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_st_i       (req_st),
      .req_size_i     (req_size),
      .req_signed_i   (req_signed),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .req_tag_i      (req_tag),
      .mem_addr_o     (mem_addr),
      .mem_we_o       (mem_we),
      .mem_din_o      (mem_din),
      .mem_valid_st_o (mem_valid_st),
      .mem_spec_ld_o  (mem_spec_ld),
      .mem_dout_i     (mem_dout),
      .rsp_valid_o    (rsp_valid),
      .rsp_data_o     (rsp_data),
      .rsp_tag_o      (rsp_tag),
      .rsp_err_o      (rsp_err)
   );

   always #5 clk = ~clk;

   // Memory model: the read captures the old word, so a same-edge write is not seen.
   always @(posedge clk) begin
      if (mem_spec_ld)
         mem_dout <= mem[mem_addr];
      if (mem_valid_st) begin
         for (int i = 0; i < 4; i++)
            if (mem_we[i])
               mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a request for one cycle; returns mid-cycle so controls can be sampled.
   task automatic issue(input logic st, input logic [1:0] size, input logic sgn,
                        input logic [AW+1:0] addr, input logic [31:0] wd,
                        input logic [TW-1:0] tag);
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_st     = st;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      req_tag    = tag;
      #3;
   endtask

   task automatic next_idle();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #3;
   endtask

   task automatic do_load(input string name, input logic [1:0] size, input logic sgn,
                          input logic [AW+1:0] addr, input logic [TW-1:0] tag,
                          input logic [31:0] exp);
      issue(1'b0, size, sgn, addr, 32'd0, tag);
      next_idle();
      check({name, "_valid"}, rsp_valid, 1'b1);
      check({name, "_data"},  rsp_data,  exp);
      check({name, "_tag"},   rsp_tag,   tag);
   endtask

   task automatic do_error(input string name, input logic st, input logic [1:0] size,
                           input logic [AW+1:0] addr, input logic [TW-1:0] tag);
      issue(st, size, 1'b0, addr, 32'hCAFEF00D, tag);
      check({name, "_no_ld"}, mem_spec_ld,  1'b0);
      check({name, "_no_st"}, mem_valid_st, 1'b0);
      check({name, "_no_we"}, mem_we,       4'b0000);
      next_idle();
      check({name, "_valid"}, rsp_valid, 1'b1);
      check({name, "_err"},   rsp_err,   1'b1);
      check({name, "_data"},  rsp_data,  32'd0);
      check({name, "_tag"},   rsp_tag,   tag);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++)
         mem[i] = 32'd0;

      // Reset behaviour
      repeat (2) @(posedge clk);
      #4;
      check("rst_ready",  req_ready, 1'b0);
      check("rst_rvalid", rsp_valid, 1'b0);
      check("rst_vst",    mem_valid_st, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      check("post_rst_ready", req_ready, 1'b1);
      check("post_rst_rval",  rsp_valid, 1'b0);
      check("post_rst_data",  rsp_data,  32'd0);
      check("post_rst_tag",   rsp_tag,   5'd0);
      check("post_rst_err",   rsp_err,   1'b0);

      // Word store then word load
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 5'd1);
      check("stw_we",   mem_we,       4'hF);
      check("stw_addr", mem_addr,     10'd4);
      check("stw_din",  mem_din,      32'hDEADBEEF);
      check("stw_vst",  mem_valid_st, 1'b1);
      check("stw_sld",  mem_spec_ld,  1'b0);
      next_idle();
      check("stw_norsp",   rsp_valid,    1'b0);
      check("idle_we",     mem_we,       4'b0000);
      check("idle_vst",    mem_valid_st, 1'b0);
      check("idle_sld",    mem_spec_ld,  1'b0);
      issue(1'b0, 2'd2, 1'b1, 12'h010, 32'd0, 5'd7);
      check("ldw_sld",  mem_spec_ld, 1'b1);
      check("ldw_we",   mem_we,      4'b0000);
      check("ldw_addr", mem_addr,    10'd4);
      next_idle();
      check("ldw_valid", rsp_valid, 1'b1);
      check("ldw_data",  rsp_data,  32'hDEADBEEF);
      check("ldw_tag",   rsp_tag,   5'd7);
      check("ldw_err",   rsp_err,   1'b0);

      // Half and byte loads across lanes
      do_load("ldh_u12", 2'd1, 1'b0, 12'h012, 5'd2, 32'h0000DEAD);
      do_load("ldh_s12", 2'd1, 1'b1, 12'h012, 5'd3, 32'hFFFFDEAD);
      do_load("ldh_u10", 2'd1, 1'b0, 12'h010, 5'd4, 32'h0000BEEF);
      do_load("ldb_s11", 2'd0, 1'b1, 12'h011, 5'd5, 32'hFFFFFFBE);
      do_load("ldb_u10", 2'd0, 1'b0, 12'h010, 5'd6, 32'h000000EF);

      // Error paths
`ifndef DMEM_LSU_MISALIGN_EN
      do_error("err_h11", 1'b0, 2'd1, 12'h011, 5'd8);
      do_error("err_w12", 1'b0, 2'd2, 12'h012, 5'd9);
      do_error("err_st11", 1'b1, 2'd2, 12'h011, 5'd10);
`endif
      do_error("err_sz3", 1'b0, 2'd3, 12'h010, 5'd11);

      // Byte store replicates the low byte
      issue(1'b1, 2'd0, 1'b0, 12'h013, 32'h12345680, 5'd0);
      check("stb_we",  mem_we,  4'b1000);
      check("stb_din", mem_din, 32'h80808080);
      next_idle();
      do_load("ldb_s13", 2'd0, 1'b1, 12'h013, 5'd12, 32'hFFFFFF80);
      do_load("ldb_u13", 2'd0, 1'b0, 12'h013, 5'd13, 32'h00000080);

      // Load then store to the same word: load sees pre-store data
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 5'd14);
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'h01020304, 5'd0);
      check("b2b_st_we",  mem_we,    4'hF);
      check("b2b_rvalid", rsp_valid, 1'b1);
      check("b2b_rdata",  rsp_data,  32'h80ADBEEF);
      check("b2b_rtag",   rsp_tag,   5'd14);
      next_idle();
      do_load("b2b_after", 2'd2, 1'b0, 12'h010, 5'd15, 32'h01020304);

      // Half store in upper lanes
      issue(1'b1, 2'd1, 1'b0, 12'h016, 32'hAAAA1234, 5'd0);
      check("sth_we",  mem_we,  4'b1100);
      check("sth_din", mem_din, 32'h12341234);
      next_idle();
      do_load("sth_chk", 2'd2, 1'b0, 12'h014, 5'd16, 32'h12340000);

      // Reset while a load is in flight drops the response
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 5'd17);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      #3;
      check("rst_fl_rval",  rsp_valid,   1'b0);
      check("rst_fl_sld",   mem_spec_ld, 1'b0);
      check("rst_fl_ready", req_ready,   1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      check("rst_fl_ready2", req_ready, 1'b1);
      check("rst_fl_rval2",  rsp_valid, 1'b0);
      check("rst_fl_tag",    rsp_tag,   5'd0);

`ifdef DMEM_LSU_MISALIGN_EN
      // Split word store across words 3 and 4
      issue(1'b1, 2'd2, 1'b0, 12'h00E, 32'h11223344, 5'd0);
      check("sp_st_a0",  mem_addr,     10'd3);
      check("sp_st_we0", mem_we,       4'b1100);
      check("sp_st_d0",  mem_din,      32'h33441122);
      check("sp_st_v0",  mem_valid_st, 1'b1);
      next_idle();
      check("sp_st_a1",  mem_addr,     10'd4);
      check("sp_st_we1", mem_we,       4'b0011);
      check("sp_st_v1",  mem_valid_st, 1'b1);
      check("sp_st_rdy", req_ready,    1'b0);
      next_idle();
      check("sp_st_rdy2", req_ready, 1'b1);
      check("sp_st_we2",  mem_we,    4'b0000);
      issue(1'b0, 2'd2, 1'b0, 12'h00E, 32'd0, 5'd9);
      check("sp_ld_a0", mem_addr,    10'd3);
      check("sp_ld_s0", mem_spec_ld, 1'b1);
      next_idle();
      check("sp_ld_a1", mem_addr,    10'd4);
      check("sp_ld_s1", mem_spec_ld, 1'b1);
      check("sp_ld_rv", rsp_valid,   1'b0);
      next_idle();
      check("sp_ld_valid", rsp_valid, 1'b1);
      check("sp_ld_data",  rsp_data,  32'h11223344);
      check("sp_ld_tag",   rsp_tag,   5'd9);
      check("sp_ld_err",   rsp_err,   1'b0);

      // Wrap from the last word to word 0
      issue(1'b1, 2'd2, 1'b0, 12'hFFD, 32'hA1B2C3D4, 5'd0);
      check("wr_st_a0",  mem_addr, 10'h3FF);
      check("wr_st_we0", mem_we,   4'b1110);
      next_idle();
      check("wr_st_a1",  mem_addr, 10'd0);
      check("wr_st_we1", mem_we,   4'b0001);
      next_idle();
      issue(1'b0, 2'd2, 1'b0, 12'hFFD, 32'd0, 5'd5);
      check("wr_ld_a0", mem_addr, 10'h3FF);
      next_idle();
      check("wr_ld_a1", mem_addr, 10'd0);
      next_idle();
      check("wr_ld_data", rsp_data, 32'hA1B2C3D4);

      // Reset during the split cycle
      issue(1'b0, 2'd2, 1'b0, 12'h00E, 32'd0, 5'd6);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      #3;
      check("sp_rst_sld",  mem_spec_ld,  1'b0);
      check("sp_rst_vst",  mem_valid_st, 1'b0);
      check("sp_rst_rval", rsp_valid,    1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #3;
      check("sp_rst_ready", req_ready, 1'b1);
      check("sp_rst_rval2", rsp_valid, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
